serial_adder: RTL
=================

# serial_adder

Bit-serial adder stage that drives the decoder-based full adder (`fa_decoder`) one bit per clock, LSB first. It is the sequential consumer of the full adder's `S`/`Cout` outputs: it shifts `S` into a result register and feeds `Cout` back as the next cycle's carry-in through a carry flip-flop. The block turns the single-bit combinational full adder into a WIDTH-bit adder with a start/done handshake, for use by datapath blocks that trade latency for area.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 1.

Ports:
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a new addition. Sampled only in IDLE.
- `a`  input  WIDTH: operand A, captured on the accepting edge.
- `b`  input  WIDTH: operand B, captured on the accepting edge.
- `cin`  input  1: initial carry-in, captured on the accepting edge.
- `busy`  output  1: high in RUN and DONE.
- `done`  output  1: one-cycle pulse, high in DONE.
- `sum`  output  WIDTH: result register, (a + b + cin) mod 2^WIDTH.
- `cout`  output  1: final carry-out, bit WIDTH of a + b + cin.

## Operation
- Internal state:
  - operand shift registers `sa` and `sb` (WIDTH each);
  - carry flip-flop `c`;
  - partial-sum shift register `ps` (WIDTH);
  - bit counter (ceil(log2(WIDTH+1)) bits);
  - FSM states IDLE, RUN, DONE.
- One `fa_decoder` instance. Its inputs are `sa[0]`, `sb[0]` and `c`; its `S` and `Cout` are consumed every RUN cycle.
- **IDLE**: if `start`=1, load `sa`←`a`, `sb`←`b`, `c`←`cin`, counter←0, then go to RUN. Otherwise hold.
- **RUN**, each edge:
  - `ps` ← {S, `ps`[WIDTH-1:1]};
  - `sa`, `sb` shift right by 1 (zero fill);
  - `c` ← Cout;
  - counter increments.
  - On the edge where counter = WIDTH-1:
    - load `sum` ← {S, `ps`[WIDTH-1:1]} and `cout` ← Cout;
    - go to DONE.
- **DONE**: `done`=1 for exactly one cycle, then unconditionally go to IDLE. `start` is ignored in DONE.
- `start` in RUN or DONE is ignored; it is neither queued nor allowed to corrupt the operation in progress.
- `sum` and `cout` change only on the RUN→DONE edge and on reset. They hold the last result through IDLE and through the next operation until its completion.
- Arithmetic is unsigned. Overflow appears only on `cout`; there is no saturation.

## Timing
- Reset values:
  - state = IDLE;
  - `busy`=0, `done`=0, `sum`=0, `cout`=0;
  - internal registers cleared.
- Reset asserted mid-operation aborts immediately, asynchronously. No `done` pulse follows the abort, and outputs take their reset values.
- Acceptance edge E0 is the edge at which IDLE samples `start`=1. Bits 0..WIDTH-1 are processed at edges E1..E_WIDTH.
- `sum`, `cout` and `done` are valid in the cycle after E_WIDTH. Latency from acceptance to `done` is WIDTH edges.
- `busy` rises after E0 and falls after E_(WIDTH+1), when the FSM returns to IDLE.
- Earliest next acceptance is at E_(WIDTH+2). Throughput is one addition per WIDTH+2 cycles.
- WIDTH=1 is legal: RUN lasts one edge.
- All outputs are registered or decoded directly from state, with no combinational path from inputs.

## Test plan
1. WIDTH=8, `a`=3, `b`=5, `cin`=0, `start` pulsed -> `done`=1 exactly 8 edges after acceptance, with `sum`=8 and `cout`=0. `busy` is high for 9 cycles.
2. `a`=255, `b`=1, `cin`=0 -> `sum`=0 and `cout`=1, checking carry ripple through every bit. Then `a`=255, `b`=255, `cin`=1 -> `sum`=255 and `cout`=1.
3. Exhaustive loop with WIDTH=3 over all a, b, cin (128 cases) -> each `sum`/`cout` matches a reference a+b+cin. Also checks that the single-bit truth table of `fa_decoder` holds in context.
4. `start` held high continuously, with `a` and `b` changing every cycle -> only IDLE samples are accepted. One addition completes per 10 cycles (WIDTH=8), each using the operands present at its acceptance edge.
5. Reset asserted at edge E4 of an operation with `a`=100, `b`=27 -> `busy`, `done`, `sum` and `cout` go to 0 without waiting for a clock edge, and no `done` pulse follows. A fresh start then yields `sum`=127 and `cout`=0.
6. After a result of `sum`=8, start `a`=1, `b`=1 -> `sum` stays 8 through RUN and becomes 2 only in the DONE cycle.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a decoder-based full adder, LSB first.
// Latency WIDTH edges from acceptance to done; start is ignored while busy.

module fa_decoder (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   logic [7:0] w_dec;

   // One-hot minterm decode of {a, b, cin}; S and Cout are ORs of their minterms.
   assign w_dec  = 8'b0000_0001 << {i_a, i_b, i_cin};
   assign o_s    = w_dec[1] | w_dec[2] | w_dec[4] | w_dec[7];
   assign o_cout = w_dec[3] | w_dec[5] | w_dec[6] | w_dec[7];

endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = (WIDTH > 1) ? WIDTH - 1 : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic             r_c;
   logic [PW-1:0]    r_ps;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;

   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic [WIDTH-1:0] w_sum_next;
   logic [PW-1:0]    w_ps_next;

   fa_decoder u_fa (
      .i_a    (r_sa[0]),
      .i_b    (r_sb[0]),
      .i_cin  (r_c),
      .o_s    (w_s),
      .o_cout (w_co)
   );

   assign w_last = (r_cnt == LAST_BIT);

   // r_ps keeps only the upper WIDTH-1 partial-sum bits; bit 0 would be shifted out unread.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sum_next = w_s;
         assign w_ps_next  = r_ps;
      end else begin : g_wn
         assign w_sum_next = {w_s, r_ps};
         assign w_ps_next  = w_sum_next[WIDTH-1:1];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next_state = S_RUN;
         S_RUN:   if (w_last) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_c    <= 1'b0;
         r_ps   <= '0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_sa  <= a;
                  r_sb  <= b;
                  r_c   <= cin;
                  r_cnt <= '0;
               end
            end
            S_RUN: begin
               r_ps  <= w_ps_next;
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_c   <= w_co;
               r_cnt <= r_cnt + CW'(1);
               // Result registers only move on the final bit so they hold the previous answer.
               if (w_last) begin
                  r_sum  <= w_sum_next;
                  r_cout <= w_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule
